// File: rtl/multicycle_cpu.sv
// Multicycle memory-to-memory CPU: 1-2 word instructions, direct/indirect operands,
// ADD/SUB/MUL/MOV, ready/valid IN and OUT ports, STOP emits its operands then halts.
module multicycle_cpu #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 6,
   parameter int PC_INIT    = 8,
   parameter int SP_INIT    = 63
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] mem,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  we,
   output logic [DATA_WIDTH-1:0] data,
   input  logic [DATA_WIDTH-1:0] in,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic [ADDR_WIDTH-1:0] sp,
   output logic                  halted,
   output logic                  err
);

   // Handshakes: a word moves on IN or OUT at a rising edge where valid and ready are both 1;
   // out_valid/out stay stable until accepted, in_ready is high only while waiting in IN.

   typedef enum logic [3:0] {
      FETCH, FETCH_W, CONST, CONST_W, RD_B, RD_B_W, RD_C, RD_C_W,
      RD_PTR, RD_PTR_W, WB, IN_WAIT, OUT_WAIT, STOP_SEQ, HALT
   } state_t;

   localparam logic [3:0] OC_MOV  = 4'h0;
   localparam logic [3:0] OC_ADD  = 4'h1;
   localparam logic [3:0] OC_SUB  = 4'h2;
   localparam logic [3:0] OC_MUL  = 4'h3;
   localparam logic [3:0] OC_IN   = 4'h7;
   localparam logic [3:0] OC_OUT  = 4'h8;
   localparam logic [3:0] OC_STOP = 4'hF;

   state_t                state, state_nx;
   logic [15:0]           ir;
   logic [DATA_WIDTH-1:0] b_val, c_val, result;
   logic [ADDR_WIDTH-1:0] ptr, ptr_a;
   logic                  deref;
   logic [1:0]            sel;
   logic [3:0]            oc, fa, fsel, rd_field;
   logic                  more, emit;
   state_t                to_wb;

   function automatic logic [ADDR_WIDTH-1:0] loc(input logic [3:0] f);
      return ADDR_WIDTH'(f[2:0]);
   endfunction

   function automatic logic legal(input logic [3:0] op);
      return op inside {OC_MOV, OC_ADD, OC_SUB, OC_MUL, OC_IN, OC_OUT, OC_STOP};
   endfunction

   assign sp     = ADDR_WIDTH'(SP_INIT);
   assign halted = (state == HALT);

   always_comb begin
      oc    = ir[15:12];
      fa    = ir[11:8];
      emit  = (oc == OC_OUT) || (oc == OC_STOP);
      to_wb = fa[3] ? RD_PTR : WB;
      case (sel)
         2'd0:    fsel = ir[11:8];
         2'd1:    fsel = ir[7:4];
         default: fsel = ir[3:0];
      endcase
      rd_field = (state == RD_C || state == RD_C_W) ? ir[3:0] : fsel;
      // An indirect field needs a second read through the pointer fetched first.
      more     = rd_field[3] && !deref;
      case (oc)
         OC_ADD:  result = b_val + c_val;
         OC_SUB:  result = b_val - c_val;
         OC_MUL:  result = b_val * c_val;
         default: result = b_val;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FETCH;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      addr     = pc;
      we       = 1'b0;
      data     = '0;
      in_ready = 1'b0;
      case (state)
         FETCH:   state_nx = FETCH_W;
         FETCH_W: begin
            case (mem[15:12])
               OC_MOV:                         state_nx = (mem[3:0] == 4'b1000) ? CONST : RD_B;
               OC_ADD, OC_SUB, OC_MUL, OC_OUT: state_nx = RD_B;
               OC_IN:                          state_nx = IN_WAIT;
               OC_STOP:                        state_nx = STOP_SEQ;
               default:                        state_nx = HALT;
            endcase
         end
         CONST:   state_nx = CONST_W;
         CONST_W: state_nx = to_wb;
         RD_B: begin
            addr     = deref ? ptr : loc(rd_field);
            state_nx = RD_B_W;
         end
         RD_B_W: begin
            if (more)              state_nx = RD_B;
            else if (emit)         state_nx = OUT_WAIT;
            else if (oc == OC_MOV) state_nx = to_wb;
            else                   state_nx = RD_C;
         end
         RD_C: begin
            addr     = deref ? ptr : loc(rd_field);
            state_nx = RD_C_W;
         end
         RD_C_W:  state_nx = more ? RD_C : to_wb;
         RD_PTR: begin
            addr     = loc(fa);
            state_nx = RD_PTR_W;
         end
         RD_PTR_W: state_nx = WB;
         WB: begin
            we       = 1'b1;
            addr     = fa[3] ? ptr_a : loc(fa);
            data     = result;
            state_nx = FETCH;
         end
         IN_WAIT: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = to_wb;
         end
         OUT_WAIT: begin
            if (out_ready) state_nx = (oc == OC_STOP) ? STOP_SEQ : FETCH;
         end
         STOP_SEQ: begin
            if (sel == 2'd3)       state_nx = HALT;
            else if (fsel != 4'h0) state_nx = RD_B;
         end
         HALT:    state_nx = HALT;
         default: state_nx = HALT;
      endcase
      if (!rst_n) addr = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc        <= ADDR_WIDTH'(PC_INIT);
         ir        <= '0;
         b_val     <= '0;
         c_val     <= '0;
         ptr       <= '0;
         ptr_a     <= '0;
         deref     <= 1'b0;
         sel       <= 2'd0;
         out       <= '0;
         out_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         case (state)
            FETCH_W: begin
               ir    <= mem[15:0];
               pc    <= pc + 1'b1;
               deref <= 1'b0;
               sel   <= (mem[15:12] == OC_OUT || mem[15:12] == OC_STOP) ? 2'd0 : 2'd1;
               err   <= !legal(mem[15:12]);
            end
            CONST_W: begin
               b_val <= mem;
               pc    <= pc + 1'b1;
            end
            RD_B_W: begin
               if (more) begin
                  ptr   <= mem[ADDR_WIDTH-1:0];
                  deref <= 1'b1;
               end else begin
                  b_val <= mem;
                  deref <= 1'b0;
                  if (emit) begin
                     out       <= mem;
                     out_valid <= 1'b1;
                  end
               end
            end
            RD_C_W: begin
               if (more) begin
                  ptr   <= mem[ADDR_WIDTH-1:0];
                  deref <= 1'b1;
               end else begin
                  c_val <= mem;
                  deref <= 1'b0;
               end
            end
            RD_PTR_W: ptr_a <= mem[ADDR_WIDTH-1:0];
            IN_WAIT:  if (in_valid) b_val <= in;
            OUT_WAIT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  sel       <= sel + 2'd1;
               end
            end
            STOP_SEQ: if (sel != 2'd3 && fsel == 4'h0) sel <= sel + 2'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: behavioural synchronous memory, hand-computed
// results, latencies, handshake holds, illegal opcode, reset abort and pc wrap.
module tb_multicycle_cpu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] mem_rd;
   logic [5:0]  addr;
   logic        we;
   logic [15:0] data;
   logic [15:0] in = 16'h0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] out;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [5:0]  pc, sp;
   logic        halted, err;

   logic [15:0] mem_arr [0:63];
   logic        load_en = 1'b0;
   logic [5:0]  load_addr = '0;
   logic [15:0] load_data = '0;

   int checks = 0;
   int errors = 0;
   int mon_viol = 0;
   int n;

   multicycle_cpu dut (
      .clk(clk), .rst_n(rst_n), .mem(mem_rd), .addr(addr), .we(we), .data(data),
      .in(in), .in_valid(in_valid), .in_ready(in_ready),
      .out(out), .out_valid(out_valid), .out_ready(out_ready),
      .pc(pc), .sp(sp), .halted(halted), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      mem_rd <= mem_arr[addr];
      if (we) mem_arr[addr] <= data;
      else if (load_en) mem_arr[load_addr] <= load_data;
   end

   always @(negedge clk) begin
      if (rst_n && in_ready && out_valid) mon_viol++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [5:0] a, input logic [15:0] d);
      @(negedge clk);
      load_en = 1'b1;
      load_addr = a;
      load_data = d;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   task automatic start_test();
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 64; i++) load(i[5:0], 16'h0000);
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic flag(input int s);
      case (s)
         0:       return we;
         1:       return in_ready;
         2:       return out_valid;
         default: return halted;
      endcase
   endfunction

   // Counts falling edges until the flag is seen; -1 when the bound expires.
   task automatic wait_flag(input int s, input int bound, output int cnt);
      cnt = 0;
      while (flag(s) !== 1'b1 && cnt < bound) begin
         @(negedge clk);
         cnt++;
      end
      if (flag(s) !== 1'b1) cnt = -1;
   endtask

   initial begin
      // Reset values
      start_test();
      check("rst_pc", pc, 6'd8);
      check("rst_sp", sp, 6'd63);
      check("rst_addr", addr, 6'd0);
      check("rst_we", we, 1'b0);
      check("rst_data", data, 16'h0);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out", out, 16'h0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_halted", halted, 1'b0);
      check("rst_err", err, 1'b0);

      // MOV constant then STOP emitting mem[1]
      load(6'd8, 16'h0108);
      load(6'd9, 16'h00AB);
      load(6'd10, 16'hF100);
      release_reset();
      wait_flag(0, 50, n);
      check("movc_latency", n, 4);
      check("movc_wb_addr", addr, 6'd1);
      check("movc_wb_data", data, 16'h00AB);
      wait_flag(2, 50, n);
      check("movc_out_seen", n >= 0, 1'b1);
      check("movc_out", out, 16'h00AB);
      @(negedge clk);
      check("movc_out_pulse", out_valid, 1'b0);
      wait_flag(3, 50, n);
      check("movc_halted", n >= 0, 1'b1);
      check("movc_pc", pc, 6'd11);
      check("movc_mem1", mem_arr[1], 16'h00AB);

      // ADD wraps, then direct MOV
      start_test();
      load(6'd1, 16'hFFFF);
      load(6'd2, 16'h0002);
      load(6'd8, 16'h1312);
      load(6'd9, 16'h0410);
      load(6'd10, 16'hF000);
      release_reset();
      wait_flag(0, 50, n);
      check("add_latency", n, 6);
      check("add_wb_addr", addr, 6'd3);
      check("add_wb_data", data, 16'h0001);
      @(negedge clk);
      check("add_we_pulse", we, 1'b0);
      wait_flag(0, 50, n);
      check("mov_latency", n, 4);
      check("mov_wb_addr", addr, 6'd4);
      wait_flag(3, 50, n);
      check("add_halted", n >= 0, 1'b1);
      check("add_mem3", mem_arr[3], 16'h0001);
      check("mov_mem4", mem_arr[4], 16'hFFFF);

      // MUL with indirect sources
      start_test();
      load(6'd4, 16'h0020);
      load(6'd32, 16'h0005);
      load(6'd8, 16'h31CC);
      load(6'd9, 16'hF000);
      release_reset();
      wait_flag(0, 50, n);
      check("mul_ind_latency", n, 10);
      check("mul_ind_addr", addr, 6'd1);
      check("mul_ind_data", data, 16'h0019);
      wait_flag(3, 50, n);
      check("mul_ind_mem1", mem_arr[1], 16'h0019);

      // SUB with indirect destination: mem[mem[4]] <= mem[1] - mem[2]
      start_test();
      load(6'd1, 16'h0003);
      load(6'd2, 16'h0005);
      load(6'd4, 16'h0021);
      load(6'd8, 16'h2C12);
      load(6'd9, 16'hF000);
      release_reset();
      wait_flag(0, 50, n);
      check("sub_inda_latency", n, 8);
      check("sub_inda_addr", addr, 6'd33);
      check("sub_inda_data", data, 16'hFFFE);

      // IN then OUT with stalled handshakes
      start_test();
      load(6'd8, 16'h7200);
      load(6'd9, 16'h8200);
      load(6'd10, 16'hF000);
      out_ready = 1'b0;
      release_reset();
      wait_flag(1, 50, n);
      check("in_ready_seen", n >= 0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("in_ready_held", in_ready, 1'b1);
      end
      in = 16'h1234;
      in_valid = 1'b1;
      @(negedge clk);
      check("in_ready_drop", in_ready, 1'b0);
      in_valid = 1'b0;
      in = 16'h0000;
      wait_flag(2, 50, n);
      check("out_valid_seen", n >= 0, 1'b1);
      check("in_mem2", mem_arr[2], 16'h1234);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("out_valid_held", out_valid, 1'b1);
         check("out_stable", out, 16'h1234);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("out_valid_drop", out_valid, 1'b0);
      check("out_keeps_value", out, 16'h1234);
      wait_flag(3, 50, n);
      check("io_halted", n >= 0, 1'b1);

      // Illegal opcode
      start_test();
      load(6'd8, 16'h5000);
      release_reset();
      wait_flag(3, 50, n);
      check("ill_latency", n, 2);
      check("ill_err", err, 1'b1);
      check("ill_pc", pc, 6'd9);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("ill_addr_frozen", addr, 6'd9);
         check("ill_no_we", we, 1'b0);
      end

      // Reset during write-back aborts the write
      start_test();
      load(6'd1, 16'hFFFF);
      load(6'd2, 16'h0002);
      load(6'd3, 16'h7777);
      load(6'd8, 16'h1312);
      release_reset();
      wait_flag(0, 50, n);
      check("abort_reached_wb", n, 6);
      rst_n = 1'b0;
      #1;
      check("abort_we", we, 1'b0);
      check("abort_addr", addr, 6'd0);
      check("abort_data", data, 16'h0);
      check("abort_pc", pc, 6'd8);
      @(negedge clk);
      check("abort_mem3", mem_arr[3], 16'h7777);

      // pc wraps 63 -> 0 (mem[8..62] hold 0x0000 = MOV mem[0]<=mem[0])
      start_test();
      load(6'd63, 16'hF000);
      release_reset();
      wait_flag(3, 400, n);
      check("wrap_halted", n >= 0, 1'b1);
      check("wrap_pc", pc, 6'd0);

      check("handshake_exclusive", mon_viol, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
